plot_stream_writer: RTL and testbench

//  Consumer end of the x/y/colour/plot pixel stream driven by drawing engines (background, agents, UI).

---
 rtl/plot_stream_writer_pkg.sv | 32 +++
 rtl/plot_stream_writer_pixel_fifo.sv | 56 +++++
 rtl/plot_stream_writer.sv | 132 +++++++++++++
 tb/tb_plot_stream_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_stream_writer_pkg.sv
// Shared screen geometry, pixel payload type and address helpers for the
// pixel stream writer and anything else that addresses the frame buffer.
package plot_stream_writer_pkg;

    localparam int unsigned SCREEN_WIDTH  = 160;
    localparam int unsigned SCREEN_HEIGHT = 120;
    localparam int unsigned X_COORD_WIDTH = 8;
    localparam int unsigned Y_COORD_WIDTH = 7;
    localparam int unsigned COLOUR_WIDTH  = 3;
    localparam int unsigned FB_ADDR_WIDTH = 15;

    typedef logic [X_COORD_WIDTH-1:0] x_coord_t;
    typedef logic [Y_COORD_WIDTH-1:0] y_coord_t;
    typedef logic [COLOUR_WIDTH-1:0]  colour_t;
    typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;

    typedef struct packed {
        x_coord_t x;
        y_coord_t y;
        colour_t  colour;
    } pixel_t;

    function automatic logic pixel_in_bounds(input x_coord_t x, input y_coord_t y);
        return (x < X_COORD_WIDTH'(SCREEN_WIDTH)) && (y < Y_COORD_WIDTH'(SCREEN_HEIGHT));
    endfunction

    // y*160 + x as a shift-add: 160 = 128 + 32
    function automatic fb_addr_t pixel_addr(input x_coord_t x, input y_coord_t y);
        return (FB_ADDR_WIDTH'(y) << 7) + (FB_ADDR_WIDTH'(y) << 5) + FB_ADDR_WIDTH'(x);
    endfunction

endpackage

// File: rtl/plot_stream_writer_pixel_fifo.sv
// Synchronous show-ahead FIFO for {addr,colour} frame-buffer writes.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/plot_stream_writer.sv
// Frame-buffer write port for the draw-engine pixel stream: registers each
// pixel, maps it to a linear address, buffers it and issues we/ready writes.
module plot_stream_writer
    import plot_stream_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [X_COORD_WIDTH-1:0] in_x,
    input  logic [Y_COORD_WIDTH-1:0] in_y,
    input  logic [COLOUR_WIDTH-1:0]  in_colour,
    input  logic                     in_plot,
    output logic                     in_ready,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [COLOUR_WIDTH-1:0]  mem_data,
    output logic                     mem_we,
    input  logic                     mem_ready,
    input  logic                     clear_status,
    output logic                     overflow,
    output logic [7:0]               oob_count,
    output logic                     idle
);

    localparam int unsigned ENTRY_W = ADDR_WIDTH + COLOUR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    pixel_t                  s1_pix;
    logic                    s1_valid;
    logic                    s1_in_bounds;
    logic [ADDR_WIDTH-1:0]   s1_addr;

    logic                    push_req;
    logic                    push_ok;
    logic                    oob_hit;
    logic                    drop_full;

    logic [ENTRY_W-1:0]      fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W-1:0]        count_next;

    // Input stage: capture the producer's pixel unconditionally every cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
        end else begin
            s1_valid <= in_plot;
            s1_pix   <= '{x: in_x, y: in_y, colour: in_colour};
        end
    end

    assign s1_in_bounds = pixel_in_bounds(s1_pix.x, s1_pix.y);
    assign s1_addr      = ADDR_WIDTH'(pixel_addr(s1_pix.x, s1_pix.y));

    assign push_req  = s1_valid && s1_in_bounds;
    assign oob_hit   = s1_valid && !s1_in_bounds;
    assign fifo_pop  = !fifo_empty && (!mem_we || mem_ready);
    assign push_ok   = push_req && (!fifo_full || fifo_pop);
    assign drop_full = push_req && fifo_full && !fifo_pop;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_pixel_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push_req),
        .push_data ({s1_addr, s1_pix.colour}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Output register refills from the FIFO when empty or as its write retires
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (fifo_pop) begin
            mem_we   <= 1'b1;
            mem_addr <= fifo_head[ENTRY_W-1:COLOUR_WIDTH];
            mem_data <= fifo_head[COLOUR_WIDTH-1:0];
        end else if (mem_ready) begin
            mem_we   <= 1'b0;
        end
    end

    // Sticky status; a drop on the clearing edge takes precedence
    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            oob_count <= '0;
        end else begin
            if (drop_full) begin
                overflow <= 1'b1;
            end else if (clear_status) begin
                overflow <= 1'b0;
            end

            if (oob_hit) begin
                if (clear_status) begin
                    oob_count <= 8'd1;
                end else if (oob_count != 8'hFF) begin
                    oob_count <= oob_count + 8'd1;
                end
            end else if (clear_status) begin
                oob_count <= '0;
            end
        end
    end

    assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(fifo_pop);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (count_next < CNT_W'(FIFO_DEPTH - 1));
        end
    end

    assign idle = !s1_valid && fifo_empty && !mem_we;

endmodule

// File: tb/tb_plot_stream_writer.sv
// Scoreboard bench for plot_stream_writer: expected writes are queued as
// pixels are driven and matched against accepted frame-buffer writes.
module tb_plot_stream_writer;
    import plot_stream_writer_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_WIDTH = 15;

    logic                     clock = 1'b0;
    logic                     resetn;
    logic [X_COORD_WIDTH-1:0] in_x;
    logic [Y_COORD_WIDTH-1:0] in_y;
    logic [COLOUR_WIDTH-1:0]  in_colour;
    logic                     in_plot;
    logic                     in_ready;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic [COLOUR_WIDTH-1:0]  mem_data;
    logic                     mem_we;
    logic                     mem_ready;
    logic                     clear_status;
    logic                     overflow;
    logic [7:0]               oob_count;
    logic                     idle;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [COLOUR_WIDTH-1:0] colour;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  writes = 0;
    bit  mon_en = 1'b0;

    plot_stream_writer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_colour    (in_colour),
        .in_plot      (in_plot),
        .in_ready     (in_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_ready    (mem_ready),
        .clear_status (clear_status),
        .overflow     (overflow),
        .oob_count    (oob_count),
        .idle         (idle)
    );

    always #5 clock = ~clock;

    // A write is taken on the next rising edge when we && ready hold at the falling edge
    always @(negedge clock) begin
        wr_t e;
        if (mon_en && resetn === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== e) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             mem_addr, mem_data, e.addr, e.colour);
                end
            end
        end
    end

    function automatic wr_t mk_wr(input int x, input int y, input int c);
        wr_t w;
        w.addr   = ADDR_WIDTH'(y * 160 + x);
        w.colour = COLOUR_WIDTH'(c);
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pixel(input int x, input int y, input int c);
        in_x      = X_COORD_WIDTH'(x);
        in_y      = Y_COORD_WIDTH'(y);
        in_colour = COLOUR_WIDTH'(c);
        in_plot   = 1'b1;
        tick();
        in_plot   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain_timeout: idle=%b after %0d cycles, expected 1", name, idle, budget);
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== '0)     begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_data !== '0)     begin errors++; $display("FAIL reset_data: got %0d expected 0", mem_data); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (oob_count !== 8'd0)  begin errors++; $display("FAIL reset_oob: got %0d expected 0", oob_count); end
        checks++; if (idle !== 1'b1)       begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        resetn = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_single_pixel();
        mem_ready = 1'b1;
        exp_q.push_back(mk_wr(3, 2, 2));
        send_pixel(3, 2, 2);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_e0: got %b expected 0", mem_we); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_e1: got %b expected 0", mem_we); end
        tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we_e2: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 15'd323) begin errors++; $display("FAIL single_addr: got %0d expected 323", mem_addr); end
        checks++; if (mem_data !== 3'b010) begin errors++; $display("FAIL single_data: got %b expected 010", mem_data); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_e3: got %b expected 0", mem_we); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_raster();
        int w0 = writes;
        mem_ready = 1'b1;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                exp_q.push_back(mk_wr(x, y, (x + y) % 8));
                send_pixel(x, y, (x + y) % 8);
            end
        end
        wait_idle(20, "raster");
        checks++; if (writes - w0 != 19200) begin errors++; $display("FAIL raster_count: got %0d expected 19200", writes - w0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL raster_pending: got %0d expected 0", exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL raster_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_stall_overflow();
        int w0 = writes;
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) exp_q.push_back(mk_wr(10 + i, 5, i));
            send_pixel(10 + i, 5, i);
        end
        repeat (3) tick();
        checks++; if (mem_we !== 1'b1)     begin errors++; $display("FAIL stall_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 15'd810) begin errors++; $display("FAIL stall_addr_hold: got %0d expected 810", mem_addr); end
        checks++; if (mem_data !== 3'd0)   begin errors++; $display("FAIL stall_data_hold: got %0d expected 0", mem_data); end
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL stall_overflow: got %b expected 1", overflow); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        mem_ready = 1'b1;
        wait_idle(30, "stall");
        checks++; if (writes - w0 != 5) begin errors++; $display("FAIL stall_count: got %0d expected 5", writes - w0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_pending: got %0d expected 0", exp_q.size()); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drained_in_ready: got %b expected 1", in_ready); end
        pulse_clear();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_out_of_bounds();
        int w0 = writes;
        mem_ready = 1'b1;
        send_pixel(160, 0, 1);
        send_pixel(0, 120, 2);
        repeat (3) tick();
        checks++; if (oob_count !== 8'd2) begin errors++; $display("FAIL oob_count: got %0d expected 2", oob_count); end
        checks++; if (writes != w0)       begin errors++; $display("FAIL oob_writes: got %0d expected 0", writes - w0); end
        checks++; if (idle !== 1'b1)      begin errors++; $display("FAIL oob_idle: got %b expected 1", idle); end
        pulse_clear();
        checks++; if (oob_count !== 8'd0) begin errors++; $display("FAIL oob_clear: got %0d expected 0", oob_count); end
        send_pixel(200, 100, 0);
        pulse_clear();
        checks++; if (oob_count !== 8'd1) begin errors++; $display("FAIL oob_clear_collision: got %0d expected 1", oob_count); end
        pulse_clear();
        for (int i = 0; i < 300; i++) send_pixel(255, 127, 7);
        repeat (2) tick();
        checks++; if (oob_count !== 8'd255) begin errors++; $display("FAIL oob_saturate: got %0d expected 255", oob_count); end
        pulse_clear();
        checks++; if (oob_count !== 8'd0) begin errors++; $display("FAIL oob_sat_clear: got %0d expected 0", oob_count); end
    endtask

    task automatic test_reset_flush();
        int w0;
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_pixel(20 + i, 9, i);
        repeat (2) tick();
        checks++; if (mem_we !== 1'b1)   begin errors++; $display("FAIL flush_pre_we: got %b expected 1", mem_we); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_overflow: got %b expected 1", overflow); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL flush_we: got %b expected 0", mem_we); end
        checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL flush_idle: got %b expected 1", idle); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", overflow); end
        w0 = writes;
        mem_ready = 1'b1;
        repeat (10) tick();
        checks++; if (writes != w0)  begin errors++; $display("FAIL flush_stale_write: got %0d writes expected 0", writes - w0); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle_after: got %b expected 1", idle); end
    endtask

    initial begin
        resetn       = 1'b0;
        in_x         = '0;
        in_y         = '0;
        in_colour    = '0;
        in_plot      = 1'b0;
        mem_ready    = 1'b0;
        clear_status = 1'b0;
        test_reset();
        test_single_pixel();
        test_raster();
        test_stall_overflow();
        test_out_of_bounds();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
